// File: rtl/dcache_dm_responder.sv
// Direct-mapped, write-back, write-allocate data cache with 256-bit lines.
// Answers the MEM-stage data port and fills/evicts whole lines over pmem_*.
module dcache_dm_responder #(
    parameter int unsigned S_INDEX  = 3,
    parameter int unsigned S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         data_read,
    input  logic         data_write,
    input  logic [3:0]   data_mbe,
    input  logic [31:0]  data_addr,
    input  logic [31:0]  data_wdata,
    output logic         data_resp,
    output logic [31:0]  data_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned S_TAG = 32 - S_INDEX - S_OFFSET;
    localparam int unsigned SETS  = 1 << S_INDEX;
    localparam int unsigned WORDS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_ALLOCATE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [SETS-1:0]            r_valid;
    logic [SETS-1:0]            r_dirty;
    logic [S_TAG-1:0]           r_tag  [SETS];
    logic [WORDS-1:0][31:0]     r_data [SETS];

    logic [S_TAG-1:0]   w_tag;
    logic [S_INDEX-1:0] w_index;
    logic [2:0]         w_word;
    logic               w_req;
    logic               w_hit;
    logic               w_store_hit;
    logic               w_wb_done;
    logic               w_fill_done;
    logic               w_unused;

    // Request address decode; byte-in-word bits carry no meaning here
    assign w_tag    = data_addr[31 -: S_TAG];
    assign w_index  = data_addr[S_OFFSET +: S_INDEX];
    assign w_word   = data_addr[4:2];
    assign w_unused = ^data_addr[1:0];

    assign w_req       = data_read | data_write;
    assign w_hit       = r_valid[w_index] & (r_tag[w_index] == w_tag);
    // read+write together is resolved as a store
    assign w_store_hit = (r_state == ST_IDLE) & w_req & w_hit & data_write;
    assign w_wb_done   = (r_state == ST_WRITEBACK) & pmem_resp;
    assign w_fill_done = (r_state == ST_ALLOCATE) & pmem_resp;

    // State register and per-set valid/dirty bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_store_hit) begin
                r_dirty[w_index] <= 1'b1;
            end
            if (w_wb_done) begin
                r_dirty[w_index] <= 1'b0;
            end
            if (w_fill_done) begin
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end
        end
    end

    // Tag and line storage: byte-merge on store hits, whole-line load on fills
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_store_hit) begin
                for (int i = 0; i < 4; i++) begin
                    if (data_mbe[i]) begin
                        r_data[w_index][w_word][i*8 +: 8] <= data_wdata[i*8 +: 8];
                    end
                end
            end
            if (w_fill_done) begin
                r_data[w_index] <= pmem_rdata;
                r_tag[w_index]  <= w_tag;
            end
        end
    end

    // Next-state and output decode; responses are combinational for 0-cycle hits
    always_comb begin
        w_next_state = r_state;
        data_resp    = 1'b0;
        data_rdata   = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        data_resp = 1'b1;
                        if (!data_write) begin
                            data_rdata = r_data[w_index][w_word];
                        end
                    end else if (r_valid[w_index] && r_dirty[w_index]) begin
                        w_next_state = ST_WRITEBACK;
                    end else begin
                        w_next_state = ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_index], w_index, {S_OFFSET{1'b0}}};
                pmem_wdata   = r_data[w_index];
                if (pmem_resp) begin
                    w_next_state = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {data_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_dm_responder.sv
// Scoreboard bench for dcache_dm_responder: stimulus queues expected events,
// a monitor pops and compares them as the cache responds or talks to memory.
module tb_dcache_dm_responder;

    localparam int unsigned LAT = 3;

    localparam int K_RESP   = 0;
    localparam int K_PREAD  = 1;
    localparam int K_PWRITE = 2;

    logic         clk;
    logic         rst;
    logic         data_read;
    logic         data_write;
    logic [3:0]   data_mbe;
    logic [31:0]  data_addr;
    logic [31:0]  data_wdata;
    logic         data_resp;
    logic [31:0]  data_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          aux;   // latency for responses, word index for evictions
    } exp_t;

    exp_t         sb [$];
    logic [255:0] mem [logic [31:0]];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           timeouts = 0;
    bit           done     = 1'b0;
    bit           inject   = 1'b0;

    dcache_dm_responder dut (
        .clk          (clk),
        .rst          (rst),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_mbe     (data_mbe),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_resp    (data_resp),
        .data_rdata   (data_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default memory contents: word i of a line = line address + i
    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = a + 32'(i);
        return l;
    endfunction

    task automatic ex(input int kind, input logic [31:0] addr, input logic [31:0] data, input int aux);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.aux = aux;
        sb.push_back(e);
    endtask

    // Hold a request until data_resp, then drop it on the following negedge
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] mbe, input logic [31:0] wd);
        bit seen;
        seen = 1'b0;
        data_read = rd; data_write = wr; data_addr = a; data_mbe = mbe; data_wdata = wd;
        for (int c = 0; c < 40; c++) begin
            #4;
            if (data_resp) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) timeouts++;
        @(negedge clk);
        data_read = 1'b0; data_write = 1'b0; data_addr = '0; data_mbe = '0; data_wdata = '0;
    endtask

    // Line-granular memory with fixed LAT-cycle response
    initial begin
        int cnt;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (inject) begin
                pmem_resp  = 1'b1;
                pmem_rdata = '1;
            end else if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt == LAT) begin
                    cnt       = 0;
                    pmem_resp = 1'b1;
                    if (pmem_write) mem[pmem_address] = pmem_wdata;
                    else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : pat(pmem_address);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: samples 1 time unit before each posedge
    initial begin
        int   lat_cnt;
        int   cyc;
        bit   prev_rst, prev_rd, prev_wr, prev_resp;
        exp_t e;
        lat_cnt = 0; cyc = 0;
        prev_rst = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (prev_rst) begin
                n_checks++;
                if (data_resp || pmem_read || pmem_write || data_rdata != 0 ||
                    pmem_address != 0 || pmem_wdata != 0) begin
                    n_fail++;
                    $display("FAIL reset_outputs: resp=%0b pread=%0b pwrite=%0b rdata=%h paddr=%h, required all zero",
                             data_resp, pmem_read, pmem_write, data_rdata, pmem_address);
                end
            end
            if (pmem_read || pmem_write) begin
                n_checks++;
                if (pmem_read && pmem_write) begin
                    n_fail++;
                    $display("FAIL pmem_exclusive: pread=1 pwrite=1, required at most one");
                end
            end
            if (rst) lat_cnt = 0;
            else if (data_read || data_write) lat_cnt++;

            if (data_resp) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_resp: got data_resp rdata=%h, required no event", data_rdata);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != K_RESP) begin
                        n_fail++;
                        $display("FAIL event_kind: got data_resp, required kind %0d addr %h", e.kind, e.addr);
                    end else begin
                        n_checks++;
                        if (data_rdata !== e.data) begin
                            n_fail++;
                            $display("FAIL rdata: got %h, required %h", data_rdata, e.data);
                        end
                        n_checks++;
                        if (lat_cnt - 1 != e.aux) begin
                            n_fail++;
                            $display("FAIL latency: got %0d, required %0d", lat_cnt - 1, e.aux);
                        end
                    end
                end
                lat_cnt = 0;
            end

            if ((pmem_read || pmem_write) &&
                (!(prev_rd || prev_wr) || prev_resp || prev_rd != pmem_read)) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pmem: pread=%0b pwrite=%0b addr=%h, required no event",
                             pmem_read, pmem_write, pmem_address);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != (pmem_write ? K_PWRITE : K_PREAD)) begin
                        n_fail++;
                        $display("FAIL event_kind: got pread=%0b pwrite=%0b addr=%h, required kind %0d addr %h",
                                 pmem_read, pmem_write, pmem_address, e.kind, e.addr);
                    end else begin
                        n_checks++;
                        if (pmem_address !== e.addr) begin
                            n_fail++;
                            $display("FAIL pmem_address: got %h, required %h", pmem_address, e.addr);
                        end
                        if (e.kind == K_PWRITE) begin
                            n_checks++;
                            if (pmem_wdata[e.aux*32 +: 32] !== e.data) begin
                                n_fail++;
                                $display("FAIL pmem_wdata_word%0d: got %h, required %h",
                                         e.aux, pmem_wdata[e.aux*32 +: 32], e.data);
                            end
                        end
                    end
                end
            end

            prev_rst  = rst;
            prev_rd   = pmem_read;
            prev_wr   = pmem_write;
            prev_resp = pmem_resp;

            if (done) break;
            if (cyc > 5000) begin
                n_checks++;
                n_fail++;
                $display("FAIL watchdog: got %0d cycles, required completion within 5000", cyc);
                break;
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events: got %0d pending, required 0", sb.size());
        end
        n_checks++;
        if (timeouts != 0) begin
            n_fail++;
            $display("FAIL request_timeout: got %0d timed-out requests, required 0", timeouts);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Directed stimulus
    initial begin
        logic [255:0] l;
        bit seen;
        rst = 1'b1; data_read = 1'b0; data_write = 1'b0;
        data_mbe = '0; data_addr = '0; data_wdata = '0;
        l = pat(32'h0000_1000);
        l[63:32] = 32'hDEAD_BEEF;
        mem[32'h0000_1000] = l;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // cold read miss
        ex(K_PREAD, 32'h0000_1000, 32'h0, 0);
        ex(K_RESP,  32'h0, 32'hDEAD_BEEF, 4);
        issue(1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0);

        // stray pmem_resp while idle must be ignored
        inject = 1'b1;
        @(negedge clk);
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);

        // read hits
        ex(K_RESP, 32'h0, 32'hDEAD_BEEF, 0);
        issue(1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0);
        ex(K_RESP, 32'h0, 32'h0000_1002, 0);
        issue(1'b1, 1'b0, 32'h0000_1008, 4'h0, 32'h0);

        // partial store then back-to-back load
        ex(K_RESP, 32'h0, 32'h0, 0);
        issue(1'b0, 1'b1, 32'h0000_1004, 4'b0011, 32'h1122_3344);
        ex(K_RESP, 32'h0, 32'hDEAD_3344, 0);
        issue(1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0);

        // zero byte-enable store leaves data intact
        ex(K_RESP, 32'h0, 32'h0, 0);
        issue(1'b0, 1'b1, 32'h0000_100C, 4'b0000, 32'hFFFF_FFFF);
        ex(K_RESP, 32'h0, 32'h0000_1003, 0);
        issue(1'b1, 1'b0, 32'h0000_100C, 4'h0, 32'h0);

        // upper-half store
        ex(K_RESP, 32'h0, 32'h0, 0);
        issue(1'b0, 1'b1, 32'h0000_1010, 4'b1100, 32'hAABB_CCDD);
        ex(K_RESP, 32'h0, 32'hAABB_1004, 0);
        issue(1'b1, 1'b0, 32'h0000_1010, 4'h0, 32'h0);

        // read and write together behave as a store
        ex(K_RESP, 32'h0, 32'h0, 0);
        issue(1'b1, 1'b1, 32'h0000_1014, 4'b1111, 32'h5566_7788);
        ex(K_RESP, 32'h0, 32'h5566_7788, 0);
        issue(1'b1, 1'b0, 32'h0000_1014, 4'h0, 32'h0);

        // dirty eviction: writeback of 0x1000 then fill of 0x1100
        ex(K_PWRITE, 32'h0000_1000, 32'hDEAD_3344, 1);
        ex(K_PREAD,  32'h0000_1100, 32'h0, 0);
        ex(K_RESP,   32'h0, 32'h0000_1101, 7);
        issue(1'b1, 1'b0, 32'h0000_1104, 4'h0, 32'h0);

        // clean eviction in set 2
        ex(K_PREAD, 32'h0000_0040, 32'h0, 0);
        ex(K_RESP,  32'h0, 32'h0000_0040, 4);
        issue(1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0);
        ex(K_PREAD, 32'h0000_0140, 32'h0, 0);
        ex(K_RESP,  32'h0, 32'h0000_0140, 4);
        issue(1'b1, 1'b0, 32'h0000_0140, 4'h0, 32'h0);

        // reset in the middle of a fill, request held throughout
        ex(K_PREAD, 32'h0000_1000, 32'h0, 0);
        ex(K_PREAD, 32'h0000_1000, 32'h0, 0);
        ex(K_RESP,  32'h0, 32'hDEAD_3344, 4);
        data_read = 1'b1;
        data_addr = 32'h0000_1004;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #4;
            if (data_resp) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) timeouts++;
        @(negedge clk);
        data_read = 1'b0;
        data_addr = '0;

        // written-back line returns intact after refill
        ex(K_RESP, 32'h0, 32'h5566_7788, 0);
        issue(1'b1, 1'b0, 32'h0000_1014, 4'h0, 32'h0);

        // set 2 was invalidated by the reset
        ex(K_PREAD, 32'h0000_0140, 32'h0, 0);
        ex(K_RESP,  32'h0, 32'h0000_0140, 4);
        issue(1'b1, 1'b0, 32'h0000_0140, 4'h0, 32'h0);

        repeat (3) @(negedge clk);
        done = 1'b1;
    end

endmodule
